// File: rtl/ram_multiport_if.sv
// Bus bundle for ram_multiport: control-side write/read request plus operand read ports.
// The control unit / ALU side uses the master modport; the RAM uses the slave modport.
interface ram_multiport_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned NRD    = 2
);
    logic                    we;
    logic                    re;
    logic [ADDR_W-1:0]       addr;
    logic [DATA_W-1:0]       data;
    logic [NRD*ADDR_W-1:0]   addrop;
    logic [DATA_W-1:0]       rdata;
    logic [NRD*DATA_W-1:0]   rdataop;
    logic                    rvalid;
    logic                    busy;

    modport master (
        output we, re, addr, data, addrop,
        input  rdata, rdataop, rvalid, busy
    );

    modport slave (
        input  we, re, addr, data, addrop,
        output rdata, rdataop, rvalid, busy
    );
endinterface

// File: rtl/ram_multiport.sv
// Register-file RAM: one write/read port plus NRD operand read ports, 1-cycle registered reads,
// zeroed by a post-reset clear sequence. Optional macro RAM_MP_BYPASS_EN enables write-to-read forwarding.
module ram_multiport #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned NRD    = 2
) (
    input logic             clock,
    input logic             reset,
    ram_multiport_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic [NRD*DATA_W-1:0]   rdataop_q, rdataop_d;
    logic                    rvalid_q, rvalid_d;
    logic                    busy_q, busy_d;

    logic [DATA_W-1:0]       mem_q [DEPTH];
    logic                    mem_we_c;
    logic [ADDR_W-1:0]       mem_waddr_c;
    logic [DATA_W-1:0]       mem_wdata_c;
    logic [ADDR_W-1:0]       op_addr_c;
    logic [DATA_W-1:0]       op_word_c;

    // Next-state, memory write selection and read-data capture.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        rdata_d     = rdata_q;
        rdataop_d   = rdataop_q;
        rvalid_d    = 1'b0;
        mem_we_c    = 1'b0;
        mem_waddr_c = clr_cnt_q;
        mem_wdata_c = '0;
        op_addr_c   = '0;
        op_word_c   = '0;

        case (state_q)
            ST_CLEAR: begin
                mem_we_c  = 1'b1;
                rdata_d   = '0;
                rdataop_d = '0;
                // Hold the counter on the last word so it never starts a second pass.
                if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                if (bus.we) begin
                    mem_we_c    = 1'b1;
                    mem_waddr_c = bus.addr;
                    mem_wdata_c = bus.data;
                end
                if (bus.re) begin
                    rvalid_d = 1'b1;
                    rdata_d  = mem_q[bus.addr];
`ifdef RAM_MP_BYPASS_EN
                    if (bus.we) begin
                        rdata_d = bus.data;
                    end
`endif
                    for (int unsigned k = 0; k < NRD; k++) begin
                        op_addr_c = bus.addrop[k*ADDR_W +: ADDR_W];
                        op_word_c = mem_q[op_addr_c];
`ifdef RAM_MP_BYPASS_EN
                        if (bus.we && (op_addr_c == bus.addr)) begin
                            op_word_c = bus.data;
                        end
`endif
                        rdataop_d[k*DATA_W +: DATA_W] = op_word_c;
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        busy_d = (state_d == ST_CLEAR);
    end

    // Control and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            rdata_q   <= '0;
            rdataop_q <= '0;
            rvalid_q  <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rdata_q   <= rdata_d;
            rdataop_q <= rdataop_d;
            rvalid_q  <= rvalid_d;
            busy_q    <= busy_d;
        end
    end

    // Storage array; contents are established by the clear sequence, not by reset.
    always_ff @(posedge clock) begin
        if (!reset && mem_we_c) begin
            mem_q[mem_waddr_c] <= mem_wdata_c;
        end
    end

    assign bus.rdata   = rdata_q;
    assign bus.rdataop = rdataop_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_ram_multiport.sv
// Scoreboard bench for ram_multiport: stimulus queues expected read results, a monitor
// pops and compares whenever rvalid is presented.
module tb_ram_multiport;
    localparam int unsigned DW  = 4;
    localparam int unsigned AW  = 4;
    localparam int unsigned NRD = 2;

    typedef struct {
        logic [DW-1:0]     rd;
        logic [NRD*DW-1:0] op;
        string             name;
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    exp_t exp_q [$];

    ram_multiport_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD)) bus ();

    ram_multiport #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD)) u_dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, want);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.we   = 1'b1;
        bus.addr = a;
        bus.data = d;
        step();
        bus.we   = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [AW-1:0] a, input logic [AW-1:0] a0,
                      input logic [AW-1:0] a1, input logic [DW-1:0] e, input logic [DW-1:0] e0,
                      input logic [DW-1:0] e1);
        exp_t x;
        bus.re     = 1'b1;
        bus.addr   = a;
        bus.addrop = {a1, a0};
        x.rd   = e;
        x.op   = {e1, e0};
        x.name = nm;
        exp_q.push_back(x);
        step();
        bus.re = 1'b0;
    endtask

    // Counts cycles with busy high, starting at the current cycle; bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
    endtask

    // Monitor: every presented read result is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.rvalid === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_rvalid: got rdata=%0h rdataop=%0h, expected no rvalid",
                             bus.rdata, bus.rdataop);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.rdata !== e.rd || bus.rdataop !== e.op) begin
                        n_fail++;
                        $display("FAIL %s: got rdata=%0h rdataop=%0h, expected rdata=%0h rdataop=%0h",
                                 e.name, bus.rdata, bus.rdataop, e.rd, e.op);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        logic [DW-1:0] e3_rd;
        exp_t x;
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        bus.we     = 1'b0;
        bus.re     = 1'b0;
        bus.addr   = '0;
        bus.data   = '0;
        bus.addrop = '0;
        step();
        chk("rst_busy",    32'(bus.busy),    32'd1);
        chk("rst_rvalid",  32'(bus.rvalid),  32'd0);
        chk("rst_rdata",   32'(bus.rdata),   32'd0);
        chk("rst_rdataop", 32'(bus.rdataop), 32'd0);

        // Requests during the clear sequence must be ignored.
        rst      = 1'b0;
        bus.we   = 1'b1;
        bus.re   = 1'b1;
        bus.addr = 4'd1;
        bus.data = 4'hF;
        count_busy(n);
        bus.we   = 1'b0;
        bus.re   = 1'b0;
        chk("clear_len", 32'(n), 32'd16);

        for (int a = 0; a < 16; a++) begin
            rd("clr_read", AW'(a), AW'(a), AW'(15 - a), 4'h0, 4'h0, 4'h0);
        end
        step();

        wr(4'd3, 4'hA);
        wr(4'd7, 4'h5);
        rd("two_ports", 4'd3, 4'd7, 4'd3, 4'hA, 4'h5, 4'hA);

        // Simultaneous write and read of the same address.
        wr(4'd4, 4'h2);
`ifdef RAM_MP_BYPASS_EN
        e3_rd = 4'h9;
`else
        e3_rd = 4'h2;
`endif
        bus.we     = 1'b1;
        bus.re     = 1'b1;
        bus.addr   = 4'd4;
        bus.data   = 4'h9;
        bus.addrop = {4'd3, 4'd4};
        x.rd   = e3_rd;
        x.op   = {4'hA, e3_rd};
        x.name = "wr_rd_same";
        exp_q.push_back(x);
        step();
        bus.we = 1'b0;
        bus.re = 1'b0;
        rd("wr_rd_after", 4'd4, 4'd4, 4'd4, 4'h9, 4'h9, 4'h9);

        // rvalid pulses once; rdata holds while the read address is rewritten.
        wr(4'd5, 4'h6);
        rd("hold_first", 4'd5, 4'd5, 4'd5, 4'h6, 4'h6, 4'h6);
        chk("hold_pulse", 32'(bus.rvalid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            bus.we   = 1'b1;
            bus.addr = 4'd5;
            bus.data = 4'hC;
            step();
            chk("hold_rvalid", 32'(bus.rvalid), 32'd0);
            chk("hold_rdata",  32'(bus.rdata),  32'h6);
        end
        bus.we = 1'b0;
        rd("hold_new", 4'd5, 4'd5, 4'd5, 4'hC, 4'hC, 4'hC);

        // Reset in the middle of a clear restarts it from address 0.
        wr(4'd12, 4'hD);
        wr(4'd15, 4'hE);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (8) step();
        chk("mid_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_busy(n);
        chk("restart_len", 32'(n), 32'd16);
        for (int a = 0; a < 16; a++) begin
            rd("restart_read", AW'(a), AW'(15 - a), AW'(a), 4'h0, 4'h0, 4'h0);
        end
        step();
        step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
